// File: rtl/ahb3lite_master_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : ahb3lite_master_arbiter_if
// Brief   : Request/grant and muxed-bus observation bundle for the arbiter.
// Revision: 1.0
// ============================================================================
interface ahb3lite_master_arbiter_if #(
    parameter int NUM_REQ = 4
);
    localparam int c_idw = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] lock;
    logic [1:0]         HTRANS;
    logic [3:0]         HBURST;
    logic               HREADY;
    logic               HRESP;
    logic [NUM_REQ-1:0] grant;
    logic [c_idw-1:0]   owner_id;
    logic               bus_idle;
    logic [c_idw-1:0]   data_owner_id;
    logic               data_valid;

    modport master (
        output req, lock, HTRANS, HBURST, HREADY, HRESP,
        input  grant, owner_id, bus_idle, data_owner_id, data_valid
    );

    modport slave (
        input  req, lock, HTRANS, HBURST, HREADY, HRESP,
        output grant, owner_id, bus_idle, data_owner_id, data_valid
    );
endinterface
`default_nettype wire

// File: rtl/ahb3lite_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : ahb3lite_master_arbiter
// Brief   : Round-robin owner arbitration of one AHB3-Lite master port.
// Revision: 1.0
// ============================================================================
module ahb3lite_master_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  wire logic                  HCLK,
    input  wire logic                  HRESETn,
    ahb3lite_master_arbiter_if.slave   bus
);
    localparam int c_idw = $clog2(NUM_REQ);

    localparam logic [1:0] c_arb_idle  = 2'd0;
    localparam logic [1:0] c_arb_owned = 2'd1;
    localparam logic [1:0] c_arb_burst = 2'd2;
    localparam logic [1:0] c_arb_incr  = 2'd3;

    localparam logic [1:0] c_htrans_idle   = 2'd0;
    localparam logic [1:0] c_htrans_nonseq = 2'd2;
    localparam logic [1:0] c_htrans_seq    = 2'd3;

    localparam logic [3:0] c_hburst_incr   = 4'd1;
    localparam logic [3:0] c_hburst_wrap4  = 4'd2;
    localparam logic [3:0] c_hburst_incr4  = 4'd3;
    localparam logic [3:0] c_hburst_wrap8  = 4'd4;
    localparam logic [3:0] c_hburst_incr8  = 4'd5;
    localparam logic [3:0] c_hburst_wrap16 = 4'd6;
    localparam logic [3:0] c_hburst_incr16 = 4'd7;

    localparam logic c_hresp_error = 1'b1;

    logic [1:0]         state_q, state_d;
    logic [4:0]         beats_left_q, beats_left_d;
    logic [c_idw-1:0]   rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [c_idw-1:0]   owner_id_q, owner_id_d;
    logic               bus_idle_q, bus_idle_d;
    logic [c_idw-1:0]   data_owner_id_q, data_owner_id_d;
    logic               data_valid_q, data_valid_d;

    logic               w_nonseq, w_seq, w_accepted, w_single;
    logic               w_last_beat, w_hold, w_error, w_ap, w_found;
    logic [4:0]         w_burst_len;
    logic [c_idw:0]     w_rr_idx;
    logic [c_idw-1:0]   w_winner, w_rr_next;

    assign w_nonseq   = (bus.HTRANS == c_htrans_nonseq);
    assign w_seq      = (bus.HTRANS == c_htrans_seq);
    assign w_accepted = bus.HREADY & (w_nonseq | w_seq);
    assign w_hold     = bus.req[owner_id_q] & bus.lock[owner_id_q];
    assign w_error    = bus.HREADY & (bus.HRESP == c_hresp_error);
    assign w_single   = w_nonseq & (bus.HBURST != c_hburst_incr) & (w_burst_len == 5'd1);
    assign w_last_beat = w_accepted &
        (w_single | (w_seq & (state_q == c_arb_burst) & (beats_left_q == 5'd1)));
    assign w_rr_next  = (w_winner == c_idw'(NUM_REQ - 1)) ? '0 : w_winner + 1'b1;

    always_comb begin
        case (bus.HBURST)
            c_hburst_wrap4,  c_hburst_incr4:  w_burst_len = 5'd4;
            c_hburst_wrap8,  c_hburst_incr8:  w_burst_len = 5'd8;
            c_hburst_wrap16, c_hburst_incr16: w_burst_len = 5'd16;
            default:                          w_burst_len = 5'd1;
        endcase
    end

    // Scan requests starting at the round-robin pointer, wrapping at NUM_REQ.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_rr_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_rr_idx = {1'b0, rr_ptr_q} + (c_idw+1)'(i);
            if (w_rr_idx >= (c_idw+1)'(NUM_REQ))
                w_rr_idx = w_rr_idx - (c_idw+1)'(NUM_REQ);
            if (!w_found && bus.req[w_rr_idx[c_idw-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_rr_idx[c_idw-1:0];
            end
        end
    end

    always_comb begin
        case (state_q)
            c_arb_idle:  w_ap = 1'b1;
            c_arb_burst: w_ap = w_last_beat;
            default:     w_ap = w_last_beat |
                                (bus.HREADY & (bus.HTRANS == c_htrans_idle) & !w_hold);
        endcase
        w_ap = w_ap | w_error;
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_q         <= c_arb_idle;
            beats_left_q    <= '0;
            rr_ptr_q        <= '0;
            grant_q         <= '0;
            owner_id_q      <= '0;
            bus_idle_q      <= 1'b1;
            data_owner_id_q <= '0;
            data_valid_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            beats_left_q    <= beats_left_d;
            rr_ptr_q        <= rr_ptr_d;
            grant_q         <= grant_d;
            owner_id_q      <= owner_id_d;
            bus_idle_q      <= bus_idle_d;
            data_owner_id_q <= data_owner_id_d;
            data_valid_q    <= data_valid_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        beats_left_d    = beats_left_q;
        rr_ptr_d        = rr_ptr_q;
        grant_d         = grant_q;
        owner_id_d      = owner_id_q;
        bus_idle_d      = bus_idle_q;
        data_owner_id_d = data_owner_id_q;
        data_valid_d    = data_valid_q;

        if (bus.HREADY) begin
            data_valid_d    = w_accepted;
            data_owner_id_d = owner_id_q;
        end

        if ((state_q != c_arb_idle) && w_accepted) begin
            if (w_nonseq) begin
                if (bus.HBURST == c_hburst_incr) begin
                    state_d      = c_arb_incr;
                    beats_left_d = '0;
                end else if (w_burst_len == 5'd1) begin
                    state_d      = c_arb_owned;
                    beats_left_d = '0;
                end else begin
                    // The NONSEQ itself is the first beat of the burst.
                    state_d      = c_arb_burst;
                    beats_left_d = w_burst_len - 5'd1;
                end
            end else if ((state_q == c_arb_burst) && (beats_left_q != 5'd0)) begin
                beats_left_d = beats_left_q - 5'd1;
            end
        end

        if (w_ap) begin
            beats_left_d = '0;
            if ((state_q != c_arb_idle) && w_hold) begin
                state_d = c_arb_owned;
            end else if (w_found) begin
                state_d             = c_arb_owned;
                grant_d             = '0;
                grant_d[w_winner]   = 1'b1;
                owner_id_d          = w_winner;
                bus_idle_d          = 1'b0;
                rr_ptr_d            = w_rr_next;
            end else begin
                state_d    = c_arb_idle;
                grant_d    = '0;
                bus_idle_d = 1'b1;
            end
        end
    end

    always_comb begin
        bus.grant         = grant_q;
        bus.owner_id      = owner_id_q;
        bus.bus_idle      = bus_idle_q;
        bus.data_owner_id = data_owner_id_q;
        bus.data_valid    = data_valid_q;
    end
endmodule
`default_nettype wire
